// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD display scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active low,
// so a 0 bit lights the segment.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Ports:
//   nibble - BCD digit; codes 10..15 are not BCD and show a dash
//   seg    - segments {g,f,e,d,c,b,a}, active low
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  nibble_t nibble,
    output seg_t    seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed driver for an N_DIGITS common-anode 7-segment display.
// A packed BCD value is latched on load and its digits are scanned one per
// slot of REFRESH_DIV cycles; the first BLANK_CYC cycles of every slot keep
// all anodes off so the previous digit cannot ghost onto the next one.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   bcd_in    - packed BCD, digit 0 in [3:0]
//   load      - capture bcd_in on this rising edge
//   seg       - segments {g,f,e,d,c,b,a}, active low, registered
//   an        - digit enables, active low, at most one low, registered
//   slot_tick - high on the last cycle of each digit slot
// Build option: define LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digit 0 is always shown; a dash counts as non-zero).
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int N_DIGITS    = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  slot_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0] latch_q;
    logic [PW-1:0]         presc_q;
    logic [IW-1:0]         idx_q;

    nibble_t               cur_nib;
    seg_t                  dec_seg;
    logic                  blank;
    logic                  suppress;
    logic [N_DIGITS-1:0]   an_sel;

    assign slot_tick = (presc_q == PW'(REFRESH_DIV - 1));
    assign blank     = (presc_q < PW'(BLANK_CYC));

    // Select the current digit's nibble and build its one-cold anode mask.
    always_comb begin
        cur_nib = '0;
        an_sel  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = latch_q[i*4 +: 4];
                an_sel[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are 0.
    // The walk runs from the most significant digit down; digit 0 is exempt.
    logic [N_DIGITS-1:0] lz;
    logic                zero_above;
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        suppress   = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (latch_q[i*4 +: 4] == 4'd0);
            lz[i]      = zero_above && (i != 0);
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                suppress = lz[i];
            end
        end
    end
`else
    assign suppress = 1'b0;
`endif

    bcd_to_7seg u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg     <= SEG_OFF;
            an      <= '1;
        end else begin
            if (load) begin
                latch_q <= bcd_in;
            end

            if (slot_tick) begin
                presc_q <= '0;
                if (idx_q == IW'(N_DIGITS - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            // Outputs reflect this cycle's prescaler/index/latch one cycle later.
            if (blank || suppress) begin
                seg <= SEG_OFF;
                an  <= '1;
            end else begin
                seg <= dec_seg;
                an  <= an_sel;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with N_DIGITS=2, REFRESH_DIV=4, BLANK_CYC=1.
// Each slot shows its digit for three cycles after one blank cycle.
module tb_bcd_display_scan;

    logic       clk;
    logic       rst;
    logic [7:0] bcd_in;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       slot_tick;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [8:0] exp_q[$];

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    bcd_display_scan #(
        .N_DIGITS    (2),
        .REFRESH_DIV (4),
        .BLANK_CYC   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .load      (load),
        .seg       (seg),
        .an        (an),
        .slot_tick (slot_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Push n display cycles of one digit: {an, seg}.
    task automatic push_slot(input logic [1:0] an_e, input logic [6:0] seg_e);
        for (int i = 0; i < 3; i++) exp_q.push_back({an_e, seg_e});
    endtask

    // Release reset with load held so the value is captured on the first edge.
    task automatic start_run(input logic [7:0] val);
        bcd_in = val;
        load   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic wait_drain_and_reset();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
            exp_q.delete();
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every lit cycle is popped against the expected queue; dark
    // cycles must also have all segments off.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (an != 2'b11) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_display: got an=%b seg=%b expected none", an, seg);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("display", {23'd0, an, seg}, {23'd0, e});
                end
            end else begin
                check("dark_seg", {25'd0, seg}, {25'd0, SOFF});
            end
        end
    end

    // Monitor: slot_tick period must be exactly REFRESH_DIV cycles.
    int  tick_gap  = 0;
    logic tick_seen = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            tick_gap  = 0;
            tick_seen = 1'b0;
        end else begin
            tick_gap++;
            if (slot_tick) begin
                if (tick_seen && mon_en) check("tick_period", tick_gap, 4);
                tick_seen = 1'b1;
                tick_gap  = 0;
            end
        end
    end

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bcd_in = 8'h00;
        #12;
        check("rst_seg", {25'd0, seg}, {25'd0, SOFF});
        check("rst_an", {30'd0, an}, 32'h3);
        check("rst_tick", {31'd0, slot_tick}, 32'd0);

        // Reset release timing and mid-run reset, checked directly.
        start_run(8'h31);
        check("blank_first_an", {30'd0, an}, 32'h3);
        @(posedge clk);
        #1;
        check("first_digit_an", {30'd0, an}, 32'h2);
        check("first_digit_seg", {25'd0, seg}, {25'd0, S1});
        rst = 1'b1;
        #1;
        check("midrst_seg", {25'd0, seg}, {25'd0, SOFF});
        check("midrst_an", {30'd0, an}, 32'h3);
        check("midrst_tick", {31'd0, slot_tick}, 32'd0);
        @(posedge clk);
        #1;

        mon_en = 1'b1;

        // Scan plus wrap: 0,1,0,1,0,1.
        for (int k = 0; k < 3; k++) begin
            push_slot(2'b10, S1);
            push_slot(2'b01, S3);
        end
        start_run(8'h31);
        wait_drain_and_reset();

        // Invalid nibble shows a dash.
        push_slot(2'b10, S7);
        push_slot(2'b01, SD);
        start_run(8'hA7);
        wait_drain_and_reset();

        // Mid-slot load: 9,9 then 2 on the cycle after the capture edge.
        exp_q.push_back({2'b10, S9});
        exp_q.push_back({2'b10, S9});
        exp_q.push_back({2'b10, S2});
`ifndef LEADING_ZERO_BLANK_EN
        push_slot(2'b01, S0);
`endif
        start_run(8'h09);
        @(posedge clk);
        #1;
        bcd_in = 8'h02;
        load   = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        wait_drain_and_reset();

        // Leading zero on digit 1.
        push_slot(2'b10, S5);
`ifndef LEADING_ZERO_BLANK_EN
        push_slot(2'b01, S0);
`endif
        push_slot(2'b10, S5);
        start_run(8'h05);
        wait_drain_and_reset();

        // All-zero value still shows digit 0.
        push_slot(2'b10, S0);
`ifndef LEADING_ZERO_BLANK_EN
        push_slot(2'b01, S0);
`endif
        push_slot(2'b10, S0);
        start_run(8'h00);
        wait_drain_and_reset();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
